// File: rtl/traffic_countdown_display.sv
// Two-digit multiplexed countdown display with a sequential double-dabble converter and registered lamp drivers.
// Optional digit/yellow-lamp blinking is compiled in when the BLINK_EN macro is defined.
module traffic_countdown_display #(
   parameter int SCAN_DIV  = 16,
   parameter int BLINK_DIV = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cnt_in,
   input  logic       red_in,
   input  logic       yellow_in,
   input  logic       green_in,
   output logic [6:0] seg,
   output logic [1:0] dig_sel,
   output logic       lamp_r,
   output logic       lamp_y,
   output logic       lamp_g,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, CONV, UPD} state_t;

   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   state_t      state_reg, state_next;
   logic [7:0]  bin_reg, bin_next;
   logic [11:0] bcd_reg, bcd_next;
   logic [11:0] bcd_adj;
   logic [2:0]  iter_reg, iter_next;
   logic [7:0]  last_val_reg, last_val_next;
   logic        last_valid_reg, last_valid_next;
   logic [3:0]  tens_reg, tens_next;
   logic [3:0]  ones_reg, ones_next;
   logic        ovf_reg, ovf_next;
   logic [SW-1:0] scan_cnt_reg;
   logic [1:0]  dig_sel_reg;
   logic        lamp_r_reg, lamp_y_reg, lamp_g_reg;
   logic [3:0]  digit;

   // Add-3 correction applied to every BCD nibble before each shift
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      bin_next        = bin_reg;
      bcd_next        = bcd_reg;
      iter_next       = iter_reg;
      last_val_next   = last_val_reg;
      last_valid_next = last_valid_reg;
      tens_next       = tens_reg;
      ones_next       = ones_reg;
      ovf_next        = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (!last_valid_reg || cnt_in != last_val_reg) begin
               bin_next      = cnt_in;
               last_val_next = cnt_in;
               bcd_next      = 12'd0;
               iter_next     = 3'd0;
               state_next    = CONV;
            end
         end
         CONV: begin
            {bcd_next, bin_next} = {bcd_adj[10:0], bin_reg, 1'b0};
            iter_next = iter_reg + 3'd1;
            if (iter_reg == 3'd7)
               state_next = UPD;
         end
         UPD: begin
            if (bcd_reg[11:8] != 4'd0) begin
               ovf_next = 1'b1;
            end else begin
               tens_next = bcd_reg[7:4];
               ones_next = bcd_reg[3:0];
               ovf_next  = 1'b0;
            end
            last_valid_next = 1'b1;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         bin_reg        <= 8'd0;
         bcd_reg        <= 12'd0;
         iter_reg       <= 3'd0;
         last_val_reg   <= 8'd0;
         last_valid_reg <= 1'b0;
         tens_reg       <= 4'd0;
         ones_reg       <= 4'd0;
         ovf_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bin_reg        <= bin_next;
         bcd_reg        <= bcd_next;
         iter_reg       <= iter_next;
         last_val_reg   <= last_val_next;
         last_valid_reg <= last_valid_next;
         tens_reg       <= tens_next;
         ones_reg       <= ones_next;
         ovf_reg        <= ovf_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt_reg <= '0;
         dig_sel_reg  <= 2'b01;
         lamp_r_reg   <= 1'b0;
         lamp_y_reg   <= 1'b0;
         lamp_g_reg   <= 1'b0;
      end else begin
         if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
            scan_cnt_reg <= '0;
            dig_sel_reg  <= ~dig_sel_reg;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
         end
         lamp_r_reg <= red_in;
         lamp_y_reg <= yellow_in;
         lamp_g_reg <= green_in;
      end
   end

`ifdef BLINK_EN
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt_reg;
   logic          phase_reg;

   // A fresh yellow period always starts in the lit phase
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b0;
      end else if (yellow_in && !lamp_y_reg) begin
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b1;
      end else if (yellow_in) begin
         if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
         end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
         end
      end
   end

   assign lamp_y = lamp_y_reg & phase_reg;
`else
   assign lamp_y = lamp_y_reg;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   always_comb begin
      seg   = 7'b0000000;
      digit = dig_sel_reg[1] ? tens_reg : ones_reg;
      if (!(red_in || yellow_in || green_in))
         seg = 7'b0000000;
      else if (ovf_reg)
         seg = 7'b1000000;
      else if (dig_sel_reg[1] && tens_reg == 4'd0)
         seg = 7'b0000000;
      else
         seg = seg7(digit);
`ifdef BLINK_EN
      if (lamp_y_reg && !phase_reg)
         seg = 7'b0000000;
`endif
   end

   assign dig_sel = dig_sel_reg;
   assign lamp_r  = lamp_r_reg;
   assign lamp_g  = lamp_g_reg;
   assign busy    = (state_reg != IDLE);
endmodule
